// File: rtl/pe_array_quant_pkg.sv
// Shared widths, lane data types and the requantisation helper for the PE array.
package pe_array_quant_pkg;

    localparam int unsigned DEF_MAC_NUM = 10;
    localparam int unsigned DEF_BW_ACT  = 8;
    localparam int unsigned DEF_BW_WET  = 8;
    localparam int unsigned DEF_BW_ACCU = 32;
    localparam int unsigned DEF_BW_OUT  = 8;
    localparam int unsigned DEF_BW_LEN  = 16;

    typedef logic signed [DEF_BW_ACT-1:0]  act_t;
    typedef logic signed [DEF_BW_WET-1:0]  wet_t;
    typedef logic signed [DEF_BW_ACCU-1:0] accu_t;
    typedef logic signed [DEF_BW_OUT-1:0]  out_t;

    // Works on a 64-bit sign-extended copy so the rounding add never overflows for any BW_ACCU <= 63.
    function automatic logic signed [63:0] requant(
        input logic signed [63:0] x,
        input logic [5:0]         shift,
        input logic               relu,
        input int unsigned        bw_accu,
        input int unsigned        bw_out
    );
        int unsigned       s;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s = (32'(shift) >= bw_accu) ? bw_accu - 1 : 32'(shift);
        r = x;
        if (s != 0) begin
            r = (x + (64'sd1 <<< (s - 1))) >>> s;
        end
        if (relu && r < 0) begin
            r = '0;
        end
        hi = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_array_quant_if.sv
// Input beat and output result streams of the PE array, both valid/ready.
interface pe_array_quant_if #(
    parameter int unsigned MAC_NUM = 10,
    parameter int unsigned BW_ACT  = 8,
    parameter int unsigned BW_WET  = 8,
    parameter int unsigned BW_ACCU = 32,
    parameter int unsigned BW_OUT  = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic [BW_ACT*MAC_NUM-1:0]   PE_act_in;
    logic [BW_WET-1:0]           PE_wet_in;
    logic [BW_ACCU*MAC_NUM-1:0]  PE_bias_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [BW_OUT*MAC_NUM-1:0]   PE_result_out;

    modport master (
        output in_valid, PE_act_in, PE_wet_in, PE_bias_in, out_ready,
        input  in_ready, out_valid, PE_result_out
    );

    modport slave (
        input  in_valid, PE_act_in, PE_wet_in, PE_bias_in, out_ready,
        output in_ready, out_valid, PE_result_out
    );
endinterface

// File: rtl/pe_array_quant_lane.sv
// One MAC lane: S1 act/bias, S2 product, S3 accumulate/psum, S4 requantised result.
module pe_lane
    import pe_array_quant_pkg::*;
#(
    parameter int unsigned BW_ACT  = DEF_BW_ACT,
    parameter int unsigned BW_WET  = DEF_BW_WET,
    parameter int unsigned BW_ACCU = DEF_BW_ACCU,
    parameter int unsigned BW_OUT  = DEF_BW_OUT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      stall,
    input  logic                      load,
    input  logic                      load_last,
    input  logic                      s1_valid,
    input  logic                      s2_valid,
    input  logic                      s2_last,
    input  logic                      s3_valid,
    input  logic signed [BW_WET-1:0]  wet,
    input  logic [5:0]                shift,
    input  logic                      relu,
    input  logic signed [BW_ACT-1:0]  act_in,
    input  logic signed [BW_ACCU-1:0] bias_in,
    output logic signed [BW_OUT-1:0]  result
);
    localparam int unsigned BW_PROD = BW_ACT + BW_WET;

    logic signed [BW_ACT-1:0]  act_r;
    logic signed [BW_ACCU-1:0] bias_r;
    logic signed [BW_PROD-1:0] prod_r;
    logic signed [BW_ACCU-1:0] bias2_r;
    logic signed [BW_ACCU-1:0] acc;
    logic signed [BW_ACCU-1:0] psum;

    // The product gets its own stage so the multiplier and the accumulate adder never share a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_r   <= '0;
            bias_r  <= '0;
            prod_r  <= '0;
            bias2_r <= '0;
            acc     <= '0;
            psum    <= '0;
            result  <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (!stall) begin
            if (load) begin
                act_r <= act_in;
            end
            if (load_last) begin
                bias_r <= bias_in;
            end
            if (s1_valid) begin
                prod_r  <= BW_PROD'(act_r) * BW_PROD'(wet);
                bias2_r <= bias_r;
            end
            if (s2_valid) begin
                if (s2_last) begin
                    psum <= acc + BW_ACCU'(prod_r) + bias2_r;
                    acc  <= '0;
                end else begin
                    acc <= acc + BW_ACCU'(prod_r);
                end
            end
            if (s3_valid) begin
                result <= BW_OUT'(requant(64'(psum), shift, relu, BW_ACCU, BW_OUT));
            end
        end
    end

endmodule

// File: rtl/pe_array_quant.sv
// PE array top: handshake, beat counter, shared valid chain and weight reg driving MAC_NUM lanes.
module pe_array_quant
    import pe_array_quant_pkg::*;
#(
    parameter int unsigned MAC_NUM = DEF_MAC_NUM,
    parameter int unsigned BW_ACT  = DEF_BW_ACT,
    parameter int unsigned BW_WET  = DEF_BW_WET,
    parameter int unsigned BW_ACCU = DEF_BW_ACCU,
    parameter int unsigned BW_OUT  = DEF_BW_OUT,
    parameter int unsigned BW_LEN  = DEF_BW_LEN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              PE_clear,
    input  logic [BW_LEN-1:0] cfg_acc_len,
    input  logic [5:0]        cfg_shift,
    input  logic              cfg_relu,
    pe_array_quant_if.slave   bus
);
    logic              stall;
    logic              accept;
    logic              beat_last;
    logic [BW_LEN-1:0] len_m1;
    logic [BW_LEN-1:0] beat_cnt;
    logic              s1_valid;
    logic              s1_last;
    logic              s2_valid;
    logic              s2_last;
    logic              s3_valid;
    logic              out_valid;
    logic [5:0]        shift_r;
    logic              relu_r;
    logic signed [BW_WET-1:0] wet_r;
    logic signed [BW_OUT-1:0] lane_res [MAC_NUM];

    assign stall        = out_valid && !bus.out_ready;
    assign bus.in_ready = reset_n && !stall && !PE_clear;
    assign accept       = bus.in_valid && bus.in_ready;
    assign len_m1       = (cfg_acc_len == '0) ? '0 : cfg_acc_len - BW_LEN'(1);
    // >= keeps the counter from running away if the length shrinks mid-pass.
    assign beat_last    = (beat_cnt >= len_m1);
    assign bus.out_valid = out_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt  <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            shift_r   <= '0;
            relu_r    <= 1'b0;
            wet_r     <= '0;
        end else if (PE_clear) begin
            beat_cnt  <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            s1_last  <= accept && beat_last;
            if (accept) begin
                wet_r    <= bus.PE_wet_in;
                beat_cnt <= beat_last ? '0 : beat_cnt + BW_LEN'(1);
            end
            s2_valid <= s1_valid;
            s2_last  <= s1_valid && s1_last;
            s3_valid <= s2_valid && s2_last;
            if (s2_valid && s2_last) begin
                shift_r <= cfg_shift;
                relu_r  <= cfg_relu;
            end
            out_valid <= s3_valid;
        end
    end

    for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
        pe_lane #(
            .BW_ACT  (BW_ACT),
            .BW_WET  (BW_WET),
            .BW_ACCU (BW_ACCU),
            .BW_OUT  (BW_OUT)
        ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .clear     (PE_clear),
            .stall     (stall),
            .load      (accept),
            .load_last (accept && beat_last),
            .s1_valid  (s1_valid),
            .s2_valid  (s2_valid),
            .s2_last   (s2_last),
            .s3_valid  (s3_valid),
            .wet       (wet_r),
            .shift     (shift_r),
            .relu      (relu_r),
            .act_in    (bus.PE_act_in[i*BW_ACT +: BW_ACT]),
            .bias_in   (bus.PE_bias_in[i*BW_ACCU +: BW_ACCU]),
            .result    (lane_res[i])
        );
        assign bus.PE_result_out[i*BW_OUT +: BW_OUT] = lane_res[i];
    end

endmodule

// File: tb/tb_pe_array_quant.sv
// Directed bench for pe_array_quant with four lanes: vector table plus multi-cycle sequences.
module tb_pe_array_quant;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        PE_clear = 1'b0;
    logic [15:0] cfg_acc_len = '0;
    logic [5:0]  cfg_shift = '0;
    logic        cfg_relu = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pe_array_quant_if #(.MAC_NUM(N)) bus ();

    pe_array_quant #(.MAC_NUM(N)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .PE_clear    (PE_clear),
        .cfg_acc_len (cfg_acc_len),
        .cfg_shift   (cfg_shift),
        .cfg_relu    (cfg_relu),
        .bus         (bus)
    );

    typedef struct packed {
        logic [15:0]  len;
        logic [5:0]   shift;
        logic         relu;
        logic [31:0]  act;
        logic [31:0]  wets;
        logic [127:0] bias;
        logic [31:0]  exp;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [31:0] p4(input int a0, input int a1, input int a2, input int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [127:0] b4(input logic [31:0] a0, input logic [31:0] a1,
                                        input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input int len, input int shift, input bit relu, input logic [31:0] act,
                                input logic [31:0] wets, input logic [127:0] bias, input logic [31:0] exp);
        vec_t v;
        v.len = 16'(len);
        v.shift = 6'(shift);
        v.relu = relu;
        v.act = act;
        v.wets = wets;
        v.bias = bias;
        v.exp = exp;
        return v;
    endfunction

    function automatic int lane_val(input int i);
        logic signed [7:0] v;
        v = bus.PE_result_out[i*8 +: 8];
        return int'(v);
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_res(input string name, input logic [31:0] exp);
        logic signed [7:0] e;
        for (int i = 0; i < N; i++) begin
            e = exp[i*8 +: 8];
            check($sformatf("%s_lane%0d", name, i), lane_val(i), int'(e));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high so consecutive calls stream beats back to back.
    task automatic send(input logic [31:0] act, input logic [7:0] wet, input logic [127:0] bias);
        int n;
        bus.in_valid = 1'b1;
        bus.PE_act_in = act;
        bus.PE_wet_in = wet;
        bus.PE_bias_in = bias;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        step();
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            step();
            n++;
        end
        check({name, "_out_valid"}, int'(bus.out_valid), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp;
        int beats;

        bus.in_valid = 1'b0;
        bus.PE_act_in = '0;
        bus.PE_wet_in = '0;
        bus.PE_bias_in = '0;
        bus.out_ready = 1'b1;

        tbl[0] = mk(3, 0, 0, p4(1, 2, 3, 4), p4(2, 3, 4, 0), b4(0, 0, 0, 0), p4(9, 18, 27, 36));
        tbl[1] = mk(1, 1, 0, p4(5, -5, 1, -1), p4(1, 0, 0, 0), b4(0, 0, 0, 0), p4(3, -2, 1, 0));
        tbl[2] = mk(1, 2, 0, p4(7, -7, 6, 2), p4(1, 0, 0, 0), b4(0, 0, 0, 0), p4(2, -2, 2, 1));
        tbl[3] = mk(1, 40, 0, p4(0, 0, 0, 0), p4(1, 0, 0, 0),
                    b4(32'h4000_0000, 32'h3FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF), p4(1, 0, -1, 1));
        tbl[4] = mk(4, 0, 0, p4(127, -128, 0, 127), p4(127, 127, 127, 127),
                    b4(0, 0, 3, 32'hFFFF_03FC), p4(127, -128, 3, 0));
        tbl[5] = mk(4, 0, 1, p4(127, -128, 0, 127), p4(127, 127, 127, 127),
                    b4(0, 0, 3, 32'hFFFF_03FC), p4(127, 0, 3, 0));
        tbl[6] = mk(2, 4, 0, p4(10, -10, 3, 100), p4(5, 6, 0, 0), b4(0, 0, -40, 16), p4(7, -7, 0, 70));
        tbl[7] = mk(0, 0, 0, p4(3, -4, 5, 0), p4(-3, 0, 0, 0), b4(1, 1, 1, 1), p4(-8, 13, -14, 1));

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", int'(bus.in_ready), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check_res("reset_result", '0);
        reset_n = 1'b1;
        step();

        // Latency: last beat accepted at edge t, out_valid rises after edge t+3.
        cfg_acc_len = 16'd1;
        send(p4(1, 2, 3, 4), 8'd3, '0);
        bus.in_valid = 1'b0;
        check("lat_t0", int'(bus.out_valid), 0);
        step();
        step();
        check("lat_t2", int'(bus.out_valid), 0);
        step();
        check("lat_t3", int'(bus.out_valid), 1);
        check_res("lat", p4(3, 6, 9, 12));
        step();

        for (int k = 0; k < 8; k++) begin
            cfg_acc_len = tbl[k].len;
            cfg_shift = tbl[k].shift;
            cfg_relu = tbl[k].relu;
            beats = (tbl[k].len == 0) ? 1 : int'(tbl[k].len);
            for (int b = 0; b < beats; b++) begin
                send(tbl[k].act, tbl[k].wets[b*8 +: 8], tbl[k].bias);
            end
            bus.in_valid = 1'b0;
            wait_out($sformatf("row%0d", k));
            check_res($sformatf("row%0d", k), tbl[k].exp);
            step();
        end

        // Backpressure: three len=2 passes, downstream stalled for five cycles.
        cfg_acc_len = 16'd2;
        cfg_shift = '0;
        cfg_relu = 1'b0;
        bus.out_ready = 1'b0;
        fork
            begin
                send(p4(1, 2, 3, 4), 8'd1, '0);
                send(p4(1, 2, 3, 4), 8'd1, '0);
                send(p4(1, 2, 3, 4), 8'd2, '0);
                send(p4(1, 2, 3, 4), 8'd3, '0);
                send(p4(1, 2, 3, 4), 8'd1, '0);
                send(p4(1, 2, 3, 4), 8'd2, '0);
                bus.in_valid = 1'b0;
            end
            begin
                wait_out("bp_p1");
                for (int c = 0; c < 5; c++) begin
                    check($sformatf("bp_stall_in_ready_%0d", c), int'(bus.in_ready), 0);
                    check($sformatf("bp_stall_hold_%0d", c), int'(bus.out_valid), 1);
                    step();
                end
                check_res("bp_p1", p4(2, 4, 6, 8));
                bus.out_ready = 1'b1;
                #1;
                check("bp_release_in_ready", int'(bus.in_ready), 1);
                step();
                wait_out("bp_p2");
                check_res("bp_p2", p4(5, 10, 15, 20));
                step();
                wait_out("bp_p3");
                check_res("bp_p3", p4(3, 6, 9, 12));
                step();
            end
        join
        repeat (3) step();
        check("bp_no_extra", int'(bus.out_valid), 0);

        // Clear after two of four beats, with a beat presented during the clear cycle.
        cfg_acc_len = 16'd4;
        send(p4(1, 1, 1, 1), 8'd9, '0);
        send(p4(1, 1, 1, 1), 8'd9, '0);
        bus.PE_act_in = p4(5, 5, 5, 5);
        PE_clear = 1'b1;
        #1;
        check("clear_in_ready", int'(bus.in_ready), 0);
        step();
        PE_clear = 1'b0;
        bus.in_valid = 1'b0;
        repeat (4) step();
        check("clear_no_out", int'(bus.out_valid), 0);
        for (int b = 0; b < 4; b++) begin
            send(p4(1, 2, 3, 4), 8'd1, '0);
        end
        bus.in_valid = 1'b0;
        wait_out("clear_fresh");
        check_res("clear_fresh", p4(4, 8, 12, 16));
        step();

        // Asynchronous reset in the middle of a pass.
        send(p4(7, 7, 7, 7), 8'd7, '0);
        send(p4(7, 7, 7, 7), 8'd7, '0);
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_mid_out_valid", int'(bus.out_valid), 0);
        check("rst_mid_in_ready", int'(bus.in_ready), 0);
        check_res("rst_mid_result", '0);
        step();
        reset_n = 1'b1;
        step();
        for (int b = 0; b < 4; b++) begin
            send(p4(1, 2, 3, 4), 8'd2, '0);
        end
        bus.in_valid = 1'b0;
        wait_out("rst_fresh");
        check_res("rst_fresh", p4(8, 16, 24, 32));
        step();

        // len=0 streamed: one result per beat, one beat per cycle.
        cfg_acc_len = 16'd0;
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    send(p4(1, 2, 3, 4), 8'(b + 1), '0);
                end
                bus.in_valid = 1'b0;
            end
            begin
                wait_out("len0_first");
                for (int b = 0; b < 4; b++) begin
                    exp = p4(b + 1, 2 * (b + 1), 3 * (b + 1), 4 * (b + 1));
                    check($sformatf("len0_valid_%0d", b), int'(bus.out_valid), 1);
                    check_res($sformatf("len0_%0d", b), exp);
                    step();
                end
                check("len0_end", int'(bus.out_valid), 0);
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
